// File: rtl/awgn_channel_adder.sv
// awgn_channel_adder
//   Channel-impairment stage that follows the AWGN generator. The 1s17 noise
//   sample is scaled by a 2u16 gain, optionally gated off, and added to the
//   transmit sample with saturation back to 1s17. An on-demand meter
//   reports the mean square of the scaled noise over 2^MEAS_LOG2 strobes.
//
// Ports
//   clk, reset_n   : clock, asynchronous active-low reset
//   clk_en         : sample strobe; datapath, acc and cnt advance only on it
//   sig_in         : transmit sample, signed 1s17
//   awgn_in        : noise sample, signed 1s17
//   noise_gain     : unsigned 2u16 gain (65536 = 1.0)
//   noise_en       : 0 forces the scaled noise to zero
//   meas_start     : single-cycle request to start a power measurement
//   sig_out        : saturated sig_in + scaled noise, signed 1s17 (2-strobe latency)
//   sat_flag       : sig_out sample was clipped
//   meas_busy      : measurement in progress (ACCUM or DONE)
//   meas_done      : one-clk pulse when noise_pwr updates
//   noise_pwr      : mean square of scaled noise, unsigned 1u17, held between runs
module awgn_channel_adder #(
  parameter int DATA_WIDTH = 18,
  parameter int MEAS_LOG2  = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clk_en,
  input  logic [DATA_WIDTH-1:0] sig_in,
  input  logic [DATA_WIDTH-1:0] awgn_in,
  input  logic [DATA_WIDTH-1:0] noise_gain,
  input  logic                  noise_en,
  input  logic                  meas_start,
  output logic [DATA_WIDTH-1:0] sig_out,
  output logic                  sat_flag,
  output logic                  meas_busy,
  output logic                  meas_done,
  output logic [DATA_WIDTH-1:0] noise_pwr
);

  localparam int PROD_W = 2 * DATA_WIDTH + 1;
  localparam int SQ_W   = 2 * DATA_WIDTH;
  localparam int ACC_W  = SQ_W + MEAS_LOG2;
  // Gain has DATA_WIDTH-2 fractional bits (2u16 for 18-bit samples).
  localparam int GAIN_FRAC = DATA_WIDTH - 2;
  // acc is in units of 2^-(2*(DATA_WIDTH-1)); divide by N and rescale to 1u17.
  localparam int PWR_SHIFT = MEAS_LOG2 + DATA_WIDTH - 1;

  localparam logic signed [PROD_W-1:0] PROD_MAX =
    {{(DATA_WIDTH + 2){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [PROD_W-1:0] PROD_MIN =
    {{(DATA_WIDTH + 2){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] S_MAX = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] S_MIN = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} meter_state_t;

  // ---------------- Stage 1: scale, floor, saturate, gate ----------------
  logic signed [DATA_WIDTH:0]   gain_s;
  logic signed [PROD_W-1:0]     prod;
  logic signed [PROD_W-1:0]     prod_shift;
  logic        [DATA_WIDTH-1:0] noise_sat;
  logic        [DATA_WIDTH-1:0] noise_r_reg;
  logic        [DATA_WIDTH-1:0] sig_r_reg;

  assign gain_s     = $signed({1'b0, noise_gain});
  assign prod       = $signed(awgn_in) * gain_s;
  assign prod_shift = prod >>> GAIN_FRAC;   // arithmetic shift = floor

  always_comb begin
    if (prod_shift > PROD_MAX)      noise_sat = S_MAX;
    else if (prod_shift < PROD_MIN) noise_sat = S_MIN;
    else                            noise_sat = prod_shift[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      noise_r_reg <= '0;
      sig_r_reg   <= '0;
    end else if (clk_en) begin
      noise_r_reg <= noise_en ? noise_sat : '0;
      sig_r_reg   <= sig_in;
    end
  end

  // ---------------- Stage 2: add and saturate ----------------
  logic [DATA_WIDTH:0]   sum;
  logic                  sum_ovf;
  logic [DATA_WIDTH-1:0] sig_out_reg;
  logic                  sat_flag_reg;

  assign sum     = {sig_r_reg[DATA_WIDTH-1], sig_r_reg} +
                   {noise_r_reg[DATA_WIDTH-1], noise_r_reg};
  // Overflow of the 1s17 range shows as disagreement of the top two bits.
  assign sum_ovf = sum[DATA_WIDTH] ^ sum[DATA_WIDTH-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sig_out_reg  <= '0;
      sat_flag_reg <= 1'b0;
    end else if (clk_en) begin
      sig_out_reg  <= sum_ovf ? (sum[DATA_WIDTH] ? S_MIN : S_MAX)
                              : sum[DATA_WIDTH-1:0];
      sat_flag_reg <= sum_ovf;
    end
  end

  assign sig_out  = sig_out_reg;
  assign sat_flag = sat_flag_reg;

  // ---------------- Noise-power meter ----------------
  meter_state_t          state_reg, state_next;
  logic [ACC_W-1:0]      acc_reg;
  logic [MEAS_LOG2-1:0]  cnt_reg;
  logic [DATA_WIDTH-1:0] noise_pwr_reg;
  logic                  acc_clr, acc_en, pwr_load;
  logic signed [SQ_W-1:0] sq;
  logic [ACC_W-1:0]      acc_sum;
  logic [DATA_WIDTH:0]   pwr_full;

  assign sq       = $signed(noise_r_reg) * $signed(noise_r_reg);
  assign acc_sum  = acc_reg + {{MEAS_LOG2{1'b0}}, sq};
  // Load noise_pwr from the final sum so it is valid during the DONE cycle.
  assign pwr_full = acc_sum[ACC_W-1:PWR_SHIFT];

  always_comb begin
    state_next = state_reg;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
    pwr_load   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (meas_start) begin
          state_next = ACCUM;
          acc_clr    = 1'b1;
        end
      end
      ACCUM: begin
        if (clk_en) begin
          acc_en = 1'b1;
          if (cnt_reg == {MEAS_LOG2{1'b1}}) begin
            state_next = DONE;
            pwr_load   = 1'b1;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_reg       <= '0;
      cnt_reg       <= '0;
      noise_pwr_reg <= '0;
    end else begin
      if (acc_clr) begin
        acc_reg <= '0;
        cnt_reg <= '0;
      end else if (acc_en) begin
        acc_reg <= acc_sum;
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (pwr_load)
        noise_pwr_reg <= pwr_full[DATA_WIDTH] ? {DATA_WIDTH{1'b1}}
                                              : pwr_full[DATA_WIDTH-1:0];
    end
  end

  assign meas_busy = (state_reg != IDLE);
  assign meas_done = (state_reg == DONE);
  assign noise_pwr = noise_pwr_reg;

endmodule

// File: tb/tb_awgn_channel_adder.sv
// Directed bench for awgn_channel_adder (MEAS_LOG2 = 4). Datapath results
// are queued when a strobe is driven and compared when they emerge two
// strobes later; the meter is checked cycle by cycle.
module tb_awgn_channel_adder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clk_en;
  logic [17:0] sig_in;
  logic [17:0] awgn_in;
  logic [17:0] noise_gain;
  logic        noise_en;
  logic        meas_start;
  logic [17:0] sig_out;
  logic        sat_flag;
  logic        meas_busy;
  logic        meas_done;
  logic [17:0] noise_pwr;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic                chk;
    logic signed [17:0]  out;
    logic                sat;
  } exp_t;
  exp_t q[$];

  awgn_channel_adder #(.DATA_WIDTH(18), .MEAS_LOG2(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clk_en     (clk_en),
    .sig_in     (sig_in),
    .awgn_in    (awgn_in),
    .noise_gain (noise_gain),
    .noise_en   (noise_en),
    .meas_start (meas_start),
    .sig_out    (sig_out),
    .sat_flag   (sat_flag),
    .meas_busy  (meas_busy),
    .meas_done  (meas_done),
    .noise_pwr  (noise_pwr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One datapath strobe; compares the result queued one strobe earlier.
  task automatic strobe(input logic signed [17:0] s, input logic signed [17:0] a,
                        input logic [17:0] g, input logic en, input logic chk,
                        input logic signed [17:0] eo, input logic es);
    exp_t e;
    sig_in = s; awgn_in = a; noise_gain = g; noise_en = en; clk_en = 1'b1;
    e.chk = chk; e.out = eo; e.sat = es;
    q.push_back(e);
    tick();
    clk_en = 1'b0;
    if (q.size() > 1) begin
      e = q.pop_front();
      if (e.chk) begin
        check("sig_out", $signed(sig_out), e.out);
        check("sat_flag", {31'd0, sat_flag}, {31'd0, e.sat});
        $display("strobe: sig_out=%0d sat_flag=%0b (expected %0d/%0b)",
                 $signed(sig_out), sat_flag, e.out, e.sat);
      end
    end
  endtask

  // Run one full measurement with a strobe every `gap` clocks and check
  // that meas_done pulses exactly once, one clk after the 16th strobe.
  task automatic run_meas(input int gap, input string tag);
    int strobes = 0;
    int pulses  = 0;
    logic was_strobe;
    meas_start = 1'b1;
    tick();
    meas_start = 1'b0;
    check({tag, "_busy_start"}, {31'd0, meas_busy}, 32'd1);
    for (int c = 0; c < 16 * gap + 2; c++) begin
      clk_en = ((c % gap) == 0) && (strobes < 16);
      was_strobe = clk_en;
      if (c == gap * 5 + 1) meas_start = 1'b1;   // ignored while busy
      tick();
      meas_start = 1'b0;
      if (was_strobe) strobes++;
      check({tag, "_done"}, {31'd0, meas_done},
            {31'd0, (strobes == 16) && was_strobe});
      if (meas_done) begin
        pulses++;
        check({tag, "_pwr"}, {14'd0, noise_pwr}, 32'd32768);
        $display("meas %s: done after strobe %0d, noise_pwr=%0d", tag, strobes, noise_pwr);
      end
    end
    clk_en = 1'b0;
    check({tag, "_pulses"}, pulses, 32'd1);
    check({tag, "_busy_end"}, {31'd0, meas_busy}, 32'd0);
    check({tag, "_pwr_hold"}, {14'd0, noise_pwr}, 32'd32768);
  endtask

  initial begin
    reset_n = 1'b0; clk_en = 1'b0; sig_in = '0; awgn_in = '0;
    noise_gain = '0; noise_en = 1'b0; meas_start = 1'b0;
    repeat (3) tick();
    check("rst_sig_out", {14'd0, sig_out}, 32'd0);
    check("rst_sat", {31'd0, sat_flag}, 32'd0);
    check("rst_busy", {31'd0, meas_busy}, 32'd0);
    check("rst_done", {31'd0, meas_done}, 32'd0);
    check("rst_pwr", {14'd0, noise_pwr}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Datapath: passthrough, gating, gain/floor, saturation.
    strobe(0, 1000, 18'd65536, 1, 1, 1000, 0);
    strobe(0, 1000, 18'd65536, 0, 1, 0, 0);
    strobe(0, 1001, 18'd32768, 1, 1, 500, 0);
    strobe(0, -1001, 18'd32768, 1, 1, -501, 0);
    strobe(0, 131071, 18'd262143, 1, 1, 131071, 0);
    strobe(131071, 1000, 18'd65536, 1, 1, 131071, 1);
    strobe(-131072, -5, 18'd65536, 1, 1, -131072, 1);
    strobe(1234, -2000, 18'd65536, 1, 1, -766, 0);
    strobe(0, 65536, 18'd65536, 1, 0, 0, 0);
    q.delete();

    // Held by clk_en low: sig_out keeps the last produced value (-766).
    repeat (3) tick();
    check("hold_sig_out", $signed(sig_out), -766);

    // Meter with continuous strobes, then with a strobe every 3rd clk.
    run_meas(1, "meter");
    run_meas(3, "gap");

    // Reset mid-measurement.
    meas_start = 1'b1;
    tick();
    meas_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      clk_en = 1'b1;
      tick();
    end
    clk_en = 1'b1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_sig_out", {14'd0, sig_out}, 32'd0);
    check("mid_rst_sat", {31'd0, sat_flag}, 32'd0);
    check("mid_rst_busy", {31'd0, meas_busy}, 32'd0);
    check("mid_rst_done", {31'd0, meas_done}, 32'd0);
    check("mid_rst_pwr", {14'd0, noise_pwr}, 32'd0);
    $display("reset mid-measurement: outputs cleared");
    repeat (2) tick();
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("no_done_after_rst", {31'd0, meas_done}, 32'd0);
    end
    clk_en = 1'b0;
    run_meas(1, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
